// File: rtl/regfile_2r1w_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Purpose : Shared encodings for the two-read / one-write register file.
//           Read-mode and write-mode codes used by the top and the read
//           formatter, plus a small helper for address range checks.
// Ports   : none (package)
// Options : none here; the top honours `REGFILE_2R1W_BYPASS_EN.
// ----------------------------------------------------------------------------
package regfile_pkg;

  // Read formatting modes
  localparam logic [1:0] RMODE_FULL = 2'b00;  // whole word
  localparam logic [1:0] RMODE_LO   = 2'b01;  // low half, zero-extended
  localparam logic [1:0] RMODE_HI   = 2'b10;  // upper half right-aligned, zero-extended
  localparam logic [1:0] RMODE_LOSX = 2'b11;  // low half, sign-extended

  // Write merge modes
  localparam logic [1:0] WMODE_FULL = 2'b00;  // replace whole word
  localparam logic [1:0] WMODE_LO   = 2'b01;  // replace low half only
  localparam logic [1:0] WMODE_HI   = 2'b10;  // replace upper half only
  localparam logic [1:0] WMODE_NOP  = 2'b11;  // reserved: no write

  // True when an address (already widened to int) names an implemented
  // register. Matters only when NREGS is not a power of two.
  function automatic logic addr_in_range(input int addr, input int nregs);
    return (addr < nregs);
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_2r1w_if.sv
// ----------------------------------------------------------------------------
// regfile_2r1w_if
// Purpose : Bundles the decode-side request signals and the read results of
//           the register file into one interface.
// Signals : readsig_a/b, sr_a/b, rmode_a/b  read requests, ports A/B
//           writesig, dr, wmode, data_write  write request
//           data_read_a/b, rvalid_a/b        registered read results
// Modports: master - requester (decode / bench) drives requests
//           slave  - register file drives read results
// Options : none
// ----------------------------------------------------------------------------
interface regfile_2r1w_if #(
  parameter int WIDTH = 20,
  parameter int NREGS = 8
);
  localparam int AW = $clog2(NREGS);

  // Port A read request
  logic             readsig_a;
  logic [AW-1:0]    sr_a;
  logic [1:0]       rmode_a;
  // Port B read request
  logic             readsig_b;
  logic [AW-1:0]    sr_b;
  logic [1:0]       rmode_b;
  // Write request
  logic             writesig;
  logic [AW-1:0]    dr;
  logic [1:0]       wmode;
  logic [WIDTH-1:0] data_write;
  // Read results
  logic [WIDTH-1:0] data_read_a;
  logic [WIDTH-1:0] data_read_b;
  logic             rvalid_a;
  logic             rvalid_b;

  modport master (
    output readsig_a, sr_a, rmode_a,
    output readsig_b, sr_b, rmode_b,
    output writesig, dr, wmode, data_write,
    input  data_read_a, data_read_b, rvalid_a, rvalid_b
  );

  modport slave (
    input  readsig_a, sr_a, rmode_a,
    input  readsig_b, sr_b, rmode_b,
    input  writesig, dr, wmode, data_write,
    output data_read_a, data_read_b, rvalid_a, rvalid_b
  );

endinterface : regfile_2r1w_if

// File: rtl/regfile_2r1w_read_fmt.sv
// ----------------------------------------------------------------------------
// regfile_read_fmt
// Purpose : Combinational read formatter: turns a raw register word into the
//           operand shape requested by rmode.
// Ports   : i_raw   [WIDTH] raw register word
//           i_rmode [2]     RMODE_FULL / RMODE_LO / RMODE_HI / RMODE_LOSX
//           o_data  [WIDTH] formatted word
// Options : none
// ----------------------------------------------------------------------------
module regfile_read_fmt
  import regfile_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] i_raw,
  input  logic [1:0]       i_rmode,
  output logic [WIDTH-1:0] o_data
);

  localparam int HALF = WIDTH / 2;

  logic [HALF-1:0] w_lo;
  logic [HALF-1:0] w_hi;

  assign w_lo = i_raw[HALF-1:0];
  assign w_hi = i_raw[WIDTH-1:HALF];

  always_comb begin
    o_data = i_raw;
    case (i_rmode)
      RMODE_FULL: o_data = i_raw;
      RMODE_LO:   o_data = {{(WIDTH-HALF){1'b0}}, w_lo};
      RMODE_HI:   o_data = {{(WIDTH-HALF){1'b0}}, w_hi};
      RMODE_LOSX: o_data = {{(WIDTH-HALF){w_lo[HALF-1]}}, w_lo};
      default:    o_data = i_raw;
    endcase
  end

endmodule : regfile_read_fmt

// File: rtl/regfile_2r1w.sv
// ----------------------------------------------------------------------------
// regfile_2r1w
// Purpose : Parametrised register file with two independent read ports and
//           one write port. Writes can replace the full word or either half;
//           reads return the full word or a zero/sign-extended half, one
//           cycle after the request.
// Ports   : clk    system clock, rising edge
//           reset  asynchronous active-high; clears registers and outputs
//           bus    regfile_2r1w_if.slave (read requests, write request,
//                  data_read_a/b, rvalid_a/b)
// Options : `REGFILE_2R1W_BYPASS_EN - when defined, a read of the register
//           being written in the same cycle returns the post-write merged
//           value; otherwise it returns the pre-write value.
// Notes   : WIDTH must be even, NREGS >= 2. AW is derived from NREGS.
// ----------------------------------------------------------------------------
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter  int WIDTH = 20,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS),
  localparam int HALF  = WIDTH / 2
) (
  input  logic           clk,
  input  logic           reset,
  regfile_2r1w_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Storage. Kept in flops rather than block RAM: every entry must clear on
  // the asynchronous reset, and two reads plus a write happen per cycle.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_regs [NREGS];

  // --------------------------------------------------------------------------
  // Write path: merge the incoming data into the current contents of dr.
  // --------------------------------------------------------------------------
  logic             w_dr_ok;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_wr_old;
  logic [WIDTH-1:0] w_wr_merged;
  logic [NREGS-1:0] w_we;

  assign w_dr_ok  = addr_in_range(int'(bus.dr), NREGS);
  // Reserved wmode and out-of-range dr both suppress the write entirely.
  assign w_wr_en  = bus.writesig && (bus.wmode != WMODE_NOP) && w_dr_ok;
  assign w_wr_old = w_dr_ok ? r_regs[bus.dr] : '0;

  always_comb begin
    w_wr_merged = w_wr_old;
    case (bus.wmode)
      WMODE_FULL: w_wr_merged = bus.data_write;
      WMODE_LO:   w_wr_merged[HALF-1:0]     = bus.data_write[HALF-1:0];
      // Upper-half writes take their data from the low half of data_write
      // so the decode stage never has to shift the operand.
      WMODE_HI:   w_wr_merged[WIDTH-1:HALF] = bus.data_write[HALF-1:0];
      default:    w_wr_merged = w_wr_old;
    endcase
  end

  // One-hot write enable per register.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_we
    assign w_we[gi] = w_wr_en && (int'(bus.dr) == gi);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_we[i]) begin
          r_regs[i] <= w_wr_merged;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. Index 0 is port A, index 1 is port B; both are identical.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic             w_req;
    logic [AW-1:0]    w_sr;
    logic [1:0]       w_rmode;
    logic             w_sr_ok;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_fmt;
    logic [WIDTH-1:0] r_data;
    logic             r_rvalid;

    assign w_req   = (gi == 0) ? bus.readsig_a : bus.readsig_b;
    assign w_sr    = (gi == 0) ? bus.sr_a      : bus.sr_b;
    assign w_rmode = (gi == 0) ? bus.rmode_a   : bus.rmode_b;
    assign w_sr_ok = addr_in_range(int'(w_sr), NREGS);

    // Unimplemented source registers read as zero (still acknowledged).
    always_comb begin
      w_raw = '0;
      if (w_sr_ok) begin
        w_raw = r_regs[w_sr];
`ifdef REGFILE_2R1W_BYPASS_EN
        // Forward the value being written this cycle so the reader sees it
        // without waiting for the register update.
        if (w_wr_en && (w_sr == bus.dr)) begin
          w_raw = w_wr_merged;
        end
`endif
      end
    end

    regfile_read_fmt #(
      .WIDTH (WIDTH)
    ) u_fmt (
      .i_raw   (w_raw),
      .i_rmode (w_rmode),
      .o_data  (w_fmt)
    );

    // data_read holds its last value between requests; rvalid is a pulse.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_data   <= '0;
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_req;
        if (w_req) begin
          r_data <= w_fmt;
        end
      end
    end
  end

  assign bus.data_read_a = g_port[0].r_data;
  assign bus.rvalid_a    = g_port[0].r_rvalid;
  assign bus.data_read_b = g_port[1].r_data;
  assign bus.rvalid_b    = g_port[1].r_rvalid;

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// ----------------------------------------------------------------------------
// tb_regfile_2r1w
// Purpose : Directed self-checking bench for regfile_2r1w (WIDTH=20, NREGS=8).
//           Expected read results are queued per port when a read is issued
//           and compared when the matching rvalid pulse is due.
// Options : honours `REGFILE_2R1W_BYPASS_EN for the same-cycle read/write case.
// ----------------------------------------------------------------------------
module tb_regfile_2r1w;
  import regfile_pkg::*;

  localparam int WIDTH = 20;
  localparam int NREGS = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  regfile_2r1w_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

  regfile_2r1w #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] q_a[$];
  logic [WIDTH-1:0] q_b[$];
  logic [WIDTH-1:0] last_a = '0;
  logic [WIDTH-1:0] last_b = '0;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.readsig_a  = 1'b0; bus.sr_a = '0; bus.rmode_a = RMODE_FULL;
    bus.readsig_b  = 1'b0; bus.sr_b = '0; bus.rmode_b = RMODE_FULL;
    bus.writesig   = 1'b0; bus.dr   = '0; bus.wmode   = WMODE_NOP;
    bus.data_write = '0;
  endtask

  task automatic wr(input int r, input logic [1:0] m, input logic [WIDTH-1:0] d);
    bus.writesig = 1'b1; bus.dr = 3'(r); bus.wmode = m; bus.data_write = d;
    $display("write   r%0d wmode=%b data=%h", r, m, d);
  endtask

  task automatic rd_a(input int r, input logic [1:0] m, input logic [WIDTH-1:0] e);
    bus.readsig_a = 1'b1; bus.sr_a = 3'(r); bus.rmode_a = m;
    q_a.push_back(e);
    $display("read A  r%0d rmode=%b expect=%h", r, m, e);
  endtask

  task automatic rd_b(input int r, input logic [1:0] m, input logic [WIDTH-1:0] e);
    bus.readsig_b = 1'b1; bus.sr_b = 3'(r); bus.rmode_b = m;
    q_b.push_back(e);
    $display("read B  r%0d rmode=%b expect=%h", r, m, e);
  endtask

  // Clock the staged requests in, then check both ports one step after the edge.
  task automatic tick();
    logic ra, rb;
    logic [WIDTH-1:0] e;
    ra = bus.readsig_a;
    rb = bus.readsig_b;
    @(posedge clk);
    #1;
    check("rvalid_a", {{(WIDTH-1){1'b0}}, bus.rvalid_a}, {{(WIDTH-1){1'b0}}, ra});
    check("rvalid_b", {{(WIDTH-1){1'b0}}, bus.rvalid_b}, {{(WIDTH-1){1'b0}}, rb});
    if (ra) begin
      e = q_a.pop_front();
      check("data_read_a", bus.data_read_a, e);
      last_a = e;
    end else begin
      check("hold_a", bus.data_read_a, last_a);
    end
    if (rb) begin
      e = q_b.pop_front();
      check("data_read_b", bus.data_read_b, e);
      last_b = e;
    end else begin
      check("hold_b", bus.data_read_b, last_b);
    end
    idle();
  endtask

  initial begin
    idle();

    // Reset state
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_rvalid_a", {{(WIDTH-1){1'b0}}, bus.rvalid_a}, '0);
    check("reset_rvalid_b", {{(WIDTH-1){1'b0}}, bus.rvalid_b}, '0);
    check("reset_data_a", bus.data_read_a, '0);
    check("reset_data_b", bus.data_read_b, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Same-cycle write and read of r3 right after reset
    wr(3, WMODE_FULL, 20'h12345);
`ifdef REGFILE_2R1W_BYPASS_EN
    rd_a(3, RMODE_FULL, 20'h12345);
`else
    rd_a(3, RMODE_FULL, 20'h00000);
`endif
    tick();
    rd_a(3, RMODE_FULL, 20'h12345);
    tick();

    // Full write then read
    wr(0, WMODE_FULL, 20'h00055);
    tick();
    rd_a(0, RMODE_FULL, 20'h00055);
    tick();

    // Half writes and upper-half read
    wr(1, WMODE_FULL, 20'hABCDE);
    tick();
    wr(1, WMODE_LO, 20'h003FF);
    rd_b(1, RMODE_HI, 20'h002AF);        // upper half unaffected by the low write
    tick();
    rd_a(1, RMODE_FULL, 20'hABFFF);
    tick();
    wr(1, WMODE_HI, 20'h00155);
    tick();
    rd_a(1, RMODE_FULL, 20'h557FF);
    rd_b(1, RMODE_LOSX, 20'hFFFFF);
    tick();

    // Both ports on one register, different modes
    wr(2, WMODE_FULL, 20'h00200);
    tick();
    rd_a(2, RMODE_LOSX, 20'hFFE00);
    rd_b(2, RMODE_LO, 20'h00200);
    tick();

    // No request: outputs hold, rvalid low
    tick();

    // Reserved write mode leaves the register untouched
    wr(5, WMODE_FULL, 20'h11111);
    tick();
    wr(5, WMODE_NOP, 20'hFFFFF);
    rd_a(5, RMODE_FULL, 20'h11111);
    tick();
    rd_a(5, RMODE_FULL, 20'h11111);
    tick();

    // Highest register
    wr(7, WMODE_FULL, 20'hFFFFF);
    tick();
    rd_a(7, RMODE_FULL, 20'hFFFFF);
    rd_b(7, RMODE_HI, 20'h003FF);
    tick();

    // Reset between edges: outputs clear at once, write to r4 is lost,
    // the read in flight is discarded.
    wr(4, WMODE_FULL, 20'h0F0F0);
    bus.readsig_a = 1'b1; bus.sr_a = 3'd7; bus.rmode_a = RMODE_FULL;
    #3;
    reset = 1'b1;
    #1;
    $display("reset   asserted mid-cycle");
    check("async_data_a", bus.data_read_a, '0);
    check("async_data_b", bus.data_read_b, '0);
    check("async_rvalid_b", {{(WIDTH-1){1'b0}}, bus.rvalid_b}, '0);
    @(posedge clk);
    #1;
    check("rst_rvalid_a", {{(WIDTH-1){1'b0}}, bus.rvalid_a}, '0);
    idle();
    reset = 1'b0;
    last_a = '0;
    last_b = '0;
    rd_a(4, RMODE_FULL, 20'h00000);
    rd_b(7, RMODE_FULL, 20'h00000);
    tick();

    // Normal operation after release
    wr(6, WMODE_FULL, 20'h0ABCD);
    tick();
    rd_a(6, RMODE_LO, 20'h003CD);
    rd_b(6, RMODE_HI, 20'h0002A);
    tick();

    check("queue_a_empty", 20'(q_a.size()), '0);
    check("queue_b_empty", 20'(q_b.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_regfile_2r1w
